// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: data width, instruction size and the
// {pc, instr} payload carried from fetch toward decode.
package cpu_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    // Canonical no-op encoding (addi x0, x0, 0) for downstream stages.
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: synchronous FIFO of fetch_entry_t.
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   push/push_data write an entry (caller guarantees space)
//   pop            drop the head (ignored while empty)
//   flush          empty the queue; wins over push and pop
//   head           current head entry, straight from storage flops
//   count          number of valid entries (0..DEPTH)
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             pop_ok;

    assign pop_ok = pop && (count != '0);
    assign head   = mem[rd_ptr];

    // Storage, pointers and occupancy; pointers wrap since DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues word-aligned requests to
// instruction memory, buffers returns with their PCs and hands them to decode.
// A redirect flushes the queue and drops every response still in flight.
// Optional build macro FETCH_PERF_EN adds perf_bubbles / perf_flushes counters.
// Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   imem_req_valid/addr/ready       fetch request channel
//   imem_rsp_valid/instr            in-order instruction return
//   out_valid/instr/pc/ready        head of prefetch queue to decode
//   redirect_valid/pc               flush and restart fetch at redirect_pc
//   perf_bubbles, perf_flushes      (FETCH_PERF_EN only) saturating counters
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_instr,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_bubbles,
    output logic [31:0] perf_flushes
`endif
);

    localparam int unsigned     CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned     SUM_W   = CNT_W + 1;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(INSTR_BYTES);

    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  rsp_pc;
    logic [XLEN-1:0]  redirect_tgt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] in_flight;
    logic [CNT_W-1:0] drop_cnt;
    logic             credit_ok;
    logic             req_fire;
    logic             push;
    logic             pop;
    fetch_entry_t     push_data;
    fetch_entry_t     head;

    assign redirect_tgt = redirect_pc & ~XLEN'(3);

    // A credit is any queue slot not already claimed by a buffered or in-flight word.
    assign credit_ok      = (SUM_W'(count) + SUM_W'(in_flight)) < SUM_W'(DEPTH);
    assign imem_req_valid = reset && !redirect_valid && credit_ok;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses are dropped while stale ones drain and in the redirect cycle itself.
    assign push           = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
    assign push_data.pc    = rsp_pc;
    assign push_data.instr = imem_rsp_instr;

    assign out_valid = (count != '0);
    assign out_instr = head.instr;
    assign out_pc    = head.pc;
    assign pop       = out_valid && out_ready;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (count)
    );

    // PC, credit and stale-response bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc  <= RESET_PC;
            rsp_pc    <= RESET_PC;
            in_flight <= '0;
            drop_cnt  <= '0;
        end else begin
            in_flight <= in_flight + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
            if (redirect_valid) begin
                fetch_pc <= redirect_tgt;
                rsp_pc   <= redirect_tgt;
                // Everything still outstanding after this edge belongs to the old path.
                drop_cnt <= in_flight - CNT_W'(imem_rsp_valid);
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + PC_STEP;
                end
                if (imem_rsp_valid) begin
                    if (drop_cnt != '0) begin
                        drop_cnt <= drop_cnt - CNT_W'(1);
                    end else begin
                        rsp_pc <= rsp_pc + PC_STEP;
                    end
                end
            end
        end
    end

`ifdef FETCH_PERF_EN
    // Saturating bubble and flush counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_bubbles <= '0;
            perf_flushes <= '0;
        end else begin
            if (out_ready && !out_valid && (perf_bubbles != '1)) begin
                perf_bubbles <= perf_bubbles + 32'd1;
            end
            if (redirect_valid && (perf_flushes != '1)) begin
                perf_flushes <= perf_flushes + 32'd1;
            end
        end
    end
`endif

`ifndef SYNTHESIS
    rsp_needs_request: assert property (@(posedge clk) disable iff (!reset)
        imem_rsp_valid |-> (in_flight != '0));

    head_stable_on_stall: assert property (@(posedge clk) disable iff (!reset)
        (out_valid && !out_ready && !redirect_valid) |=> ($stable(out_instr) && $stable(out_pc)));
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised scoreboard bench for fetch_stage. The reference model is the
// architectural instruction stream: after reset or a redirect, decode must see
// consecutive words start, start+4, ... each carrying the memory word at that PC.
module tb_fetch_stage;

    localparam int unsigned DEPTH      = 4;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int unsigned STREAM_LEN = 512;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_instr;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_bubbles;
    logic [31:0] perf_flushes;
`endif

    fetch_stage #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_instr (imem_rsp_instr),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_bubbles   (perf_bubbles),
        .perf_flushes   (perf_flushes)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        logic [31:0] addr;
    } mem_req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    mem_req_t    pend[$];
    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned lat = 1;
    int unsigned n_req = 0;
    int unsigned n_pop = 0;
    int unsigned last_req_cyc = 0;
    int unsigned last_pop_cyc = 0;
    int unsigned flushes_exp = 0;
    logic [31:0] last_req_addr = '0;
    logic        chk_next_req = 1'b0;
    logic [31:0] next_req_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic load_stream(input logic [31:0] start);
        logic [31:0] pc;
        pc = start;
        exp_q.delete();
        for (int i = 0; i < int'(STREAM_LEN); i++) begin
            exp_q.push_back('{pc, mem_word(pc)});
            pc = pc + 32'd4;
        end
    endtask

    // One clock: observe handshakes before the edge, then drive the memory response.
    task automatic step();
        @(negedge clk);
        if (reset === 1'b1) begin
            if (redirect_valid === 1'b1) begin
                check32("no_req_on_redirect", {31'd0, imem_req_valid}, 32'd0);
            end
            if (imem_req_valid && imem_req_ready) begin
                check32("req_align", {30'd0, imem_req_addr[1:0]}, 32'd0);
                if (chk_next_req) begin
                    check32("first_req_addr", imem_req_addr, next_req_addr);
                    chk_next_req = 1'b0;
                end
                pend.push_back('{cyc + lat, imem_req_addr});
                n_req++;
                last_req_addr = imem_req_addr;
                last_req_cyc  = cyc;
            end
            if (imem_rsp_valid) begin
                void'(pend.pop_front());
            end
            if (out_valid && out_ready && !redirect_valid) begin
                n_pop++;
                last_pop_cyc = cyc;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_instr = mem_word(pend[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_instr = $urandom;
        end
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        load_stream(pc & 32'hFFFF_FFFC);
        chk_next_req   = 1'b1;
        next_req_addr  = pc & 32'hFFFF_FFFC;
        flushes_exp++;
        step();
        redirect_valid = 1'b0;
    endtask

    // Asserts reset immediately (off the clock edge), holds it, releases after an edge.
    task automatic do_reset(input int unsigned hold);
        reset          = 1'b0;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        pend.delete();
        #1;
        check32("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check32("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
`ifdef FETCH_PERF_EN
        check32("rst_perf_bubbles", perf_bubbles, 32'd0);
        check32("rst_perf_flushes", perf_flushes, 32'd0);
`endif
        repeat (hold) @(posedge clk);
        #1;
        check32("rst_out_pc", out_pc, 32'd0);
        check32("rst_out_instr", out_instr, 32'd0);
        load_stream(RESET_PC);
        flushes_exp   = 0;
        chk_next_req  = 1'b1;
        next_req_addr = RESET_PC;
        reset         = 1'b1;
    endtask

    // Monitor: every accepted decode word must be the next word of the expected stream.
    exp_t        mon_e;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_pc = '0;
    logic [31:0] prev_instr = '0;

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (prev_stall) begin
                check32("stall_pc_stable", out_pc, prev_pc);
                check32("stall_instr_stable", out_instr, prev_instr);
            end
            if (redirect_valid !== 1'b1 && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_stream: popped pc 0x%08h with nothing expected", out_pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check32("out_pc", out_pc, mon_e.pc);
                    check32("out_instr", out_instr, mon_e.instr);
                end
            end
            prev_stall = out_valid && !out_ready && !redirect_valid;
            prev_pc    = out_pc;
            prev_instr = out_instr;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned edges;
        int unsigned p0;
        int unsigned r0;
        int unsigned k;
        int unsigned pop_c;
        int unsigned since;

        reset          = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_instr = '0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        @(posedge clk);
        #1;

        // Reset release, 1-cycle memory, decode always ready.
        lat = 1;
        do_reset(3);
        edges = 0;
        while (!out_valid && edges < 10) begin
            step();
            edges++;
        end
        check32("first_valid_edges", 32'(edges), 32'd2);
        p0 = n_pop;
        repeat (20) step();
        check32("throughput_20", 32'(n_pop - p0), 32'd20);

        // Decode stalled: exactly DEPTH requests, then credit released by first pop.
        out_ready = 1'b0;
        do_reset(2);
        r0 = n_req;
        repeat (12) step();
        check32("full_req_count", 32'(n_req - r0), 32'(DEPTH));
        check32("full_last_addr", last_req_addr, 32'h0000_000C);
        check32("full_req_valid_low", {31'd0, imem_req_valid}, 32'd0);
        out_ready = 1'b1;
        p0 = n_pop;
        k = 0;
        while (n_pop == p0 && k < 10) begin
            step();
            k++;
        end
        pop_c = last_pop_cyc;
        r0 = n_req;
        while (n_req == r0 && k < 20) begin
            step();
            k++;
        end
        check32("refill_addr", last_req_addr, 32'h0000_0010);
        check32("refill_delay", 32'(last_req_cyc - pop_c), 32'd1);

        // 3-cycle memory, redirect with two requests outstanding.
        lat = 3;
        imem_req_ready = 1'b0;
        do_reset(2);
        imem_req_ready = 1'b1;
        step();
        step();
        imem_req_ready = 1'b0;
        check32("two_in_flight", 32'(pend.size()), 32'd2);
        do_redirect(32'h0000_0100);
        imem_req_ready = 1'b1;
        p0 = n_pop;
        k = 0;
        while (n_pop == p0 && k < 20) begin
            step();
            k++;
        end
        check32("redir_pop_seen", {31'd0, (n_pop != p0)}, 32'd1);
        repeat (6) step();

        // Redirect coinciding with a response and a pop.
        lat = 1;
        repeat (8) step();
        do_redirect(32'h0000_0240);
        check32("flush_empty", {31'd0, out_valid}, 32'd0);
        repeat (10) step();

        // Misaligned redirect target and address wrap.
        do_redirect(32'hFFFF_FFFE);
        repeat (10) step();

        // Reset in the middle of a full queue.
        out_ready = 1'b0;
        repeat (10) step();
        check32("pre_reset_full", {31'd0, out_valid}, 32'd1);
        #2;
        do_reset(2);
        out_ready = 1'b1;
        repeat (10) step();

        // Random traffic with random redirects.
        since = 0;
        for (int i = 0; i < 1500; i++) begin
            imem_req_ready = ($urandom_range(3) != 0);
            out_ready      = ($urandom_range(9) < 7);
            lat            = $urandom_range(4, 1);
            if ($urandom_range(29) == 0 || since > 300) begin
                do_redirect($urandom);
                since = 0;
            end else begin
                step();
                since++;
            end
        end
        out_ready = 1'b1;
        imem_req_ready = 1'b1;
        repeat (10) step();

`ifdef FETCH_PERF_EN
        check32("perf_flushes", perf_flushes, 32'(flushes_exp));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
